// File: rtl/axi_rd_mem_responder.sv
//==============================================================================
// Module      : axi_rd_mem_responder
// Description : AXI4 read-channel responder backed by a 64-bit word memory with
//               a side preload port. Optional AXI_RD_ERR_CHECK_EN enables SLVERR.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_rd_mem_responder #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ID_WIDTH-1:0]      s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic [7:0]               s_axi_arlen,
    input  logic [2:0]               s_axi_arsize,
    input  logic [1:0]               s_axi_arburst,
    input  logic                     s_axi_arlock,
    input  logic [3:0]               s_axi_arcache,
    input  logic [2:0]               s_axi_arprot,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [ID_WIDTH-1:0]      s_axi_rid,
    output logic [DATA_WIDTH-1:0]    s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rlast,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    input  logic                     mem_we,
    input  logic [$clog2(DEPTH)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]    mem_wdata
);

    localparam int c_IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LAT   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_arready;
    logic                    r_rvalid;
    logic                    r_rlast;
    logic [ID_WIDTH-1:0]     r_rid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [1:0]              r_burst;
    logic [7:0]              r_cnt;
    logic [3:0]              r_lat;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_ar_hs;
    logic                    w_r_hs;
    logic                    w_load;
    logic [ADDR_WIDTH-1:0]   w_cur_addr;
    logic [7:0]              w_cur_len;
    logic [1:0]              w_cur_burst;
    logic [7:0]              w_cur_cnt;
    logic                    w_wrap_ok;
    logic [ADDR_WIDTH-1:0]   w_inc;
    logic [ADDR_WIDTH-1:0]   w_mask;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic [c_IDX_W-1:0]      w_idx;
    logic                    w_beat_err;

    assign w_ar_hs = s_axi_arvalid & r_arready;
    assign w_r_hs  = r_rvalid & s_axi_rready;

    // In IDLE the beat source is the live AR request so a zero-latency burst
    // can load beat 0 on the handshake edge itself.
    assign w_cur_addr  = (r_state == S_IDLE) ? s_axi_araddr  : r_addr;
    assign w_cur_len   = (r_state == S_IDLE) ? s_axi_arlen   : r_len;
    assign w_cur_burst = (r_state == S_IDLE) ? s_axi_arburst : r_burst;
    assign w_cur_cnt   = (r_state == S_IDLE) ? s_axi_arlen   : r_cnt;

    assign w_wrap_ok = (w_cur_len == 8'd1) || (w_cur_len == 8'd3) ||
                       (w_cur_len == 8'd7) || (w_cur_len == 8'd15);
    assign w_inc     = w_cur_addr + ADDR_WIDTH'(8);
    assign w_mask    = {{(ADDR_WIDTH-11){1'b0}}, w_cur_len, 3'b111};
    assign w_idx     = w_cur_addr[3 +: c_IDX_W];

    always_comb begin
        w_next_addr = w_inc;
        case (w_cur_burst)
            2'b00:   w_next_addr = w_cur_addr;
            2'b10:   w_next_addr = w_wrap_ok ? ((w_cur_addr & ~w_mask) | (w_inc & w_mask))
                                             : w_inc;
            default: w_next_addr = w_inc;
        endcase
    end

    assign w_load = ((r_state == S_IDLE) && w_ar_hs && (RD_LATENCY == 0)) ||
                    ((r_state == S_LAT) && (r_lat == 4'd0)) ||
                    ((r_state == S_BURST) && w_r_hs && !r_rlast);

`ifdef AXI_RD_ERR_CHECK_EN
    logic       r_bad;
    logic [1:0] r_rresp;
    logic       w_cur_bad;

    assign w_cur_bad  = (r_state == S_IDLE)
                        ? ((s_axi_arsize != 3'b011) || ((s_axi_arburst == 2'b10) && !w_wrap_ok))
                        : r_bad;
    assign w_beat_err = w_cur_bad | (|w_cur_addr[ADDR_WIDTH-1:3+c_IDX_W]);
    assign s_axi_rresp = r_rresp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bad   <= 1'b0;
            r_rresp <= 2'b00;
        end else begin
            if ((r_state == S_IDLE) && w_ar_hs)
                r_bad <= w_cur_bad;
            if (w_load)
                r_rresp <= w_beat_err ? 2'b10 : 2'b00;
        end
    end

    logic w_unused_inputs;
    assign w_unused_inputs = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot};
`else
    assign w_beat_err  = 1'b0;
    assign s_axi_rresp = 2'b00;

    logic w_unused_inputs;
    assign w_unused_inputs = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arsize};
`endif

    // Preload port; a same-cycle beat read of this word sees the old contents.
    always_ff @(posedge clk) begin
        if (mem_we)
            r_mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_len     <= 8'd0;
            r_burst   <= 2'b00;
            r_cnt     <= 8'd0;
            r_lat     <= 4'd0;
        end else begin
            if (w_load) begin
                r_rvalid <= 1'b1;
                r_rlast  <= (w_cur_cnt == 8'd0);
                r_cnt    <= w_cur_cnt - 8'd1;
                r_addr   <= w_next_addr;
                r_rdata  <= w_beat_err ? '0 : r_mem[w_idx];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rid     <= s_axi_arid;
                        r_len     <= s_axi_arlen;
                        r_burst   <= s_axi_arburst;
                        if (RD_LATENCY == 0) begin
                            r_state <= S_BURST;
                        end else begin
                            r_addr  <= s_axi_araddr;
                            r_cnt   <= s_axi_arlen;
                            r_lat   <= 4'(RD_LATENCY - 1);
                            r_state <= S_LAT;
                        end
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                S_LAT: begin
                    if (r_lat == 4'd0)
                        r_state <= S_BURST;
                    else
                        r_lat <= r_lat - 4'd1;
                end
                S_BURST: begin
                    if (w_r_hs && r_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_mem_responder.sv
//==============================================================================
// Module      : tb_axi_rd_mem_responder
// Description : Directed self-checking bench for axi_rd_mem_responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axi_rd_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] s_axi_arid;
    logic [63:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arlock;
    logic [3:0]  s_axi_arcache;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [12:0] s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [63:0] mem_wdata;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_data [16];
    logic [1:0]  exp_resp [16];

    always #5 clk = ~clk;

    axi_rd_mem_responder dut (
        .clk(clk), .reset(reset),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_ar(input logic [12:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        @(negedge clk);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !s_axi_arready; i++) @(negedge clk);
        chk("ar_ready", {63'd0, s_axi_arready}, 64'd1);
        @(posedge clk);
        #1 s_axi_arvalid = 1'b0;
    endtask

    // Accept 'stop' beats of an n-beat burst, checking each accepted beat and
    // that a stalled beat holds its data.
    task automatic collect(input int n, input int stop, input bit toggle,
                           input bit first_now, input logic [12:0] id);
        int k = 0;
        bit ph = 1'b0;
        bit held_v = 1'b0;
        logic [63:0] held = '0;
        for (int c = 0; c < 200 && k < stop; c++) begin
            @(negedge clk);
            if (first_now && c == 0) chk("first_rvalid_time", {63'd0, s_axi_rvalid}, 64'd1);
            s_axi_rready = toggle ? ~ph : 1'b1;
            ph = ~ph;
            if (s_axi_rvalid) begin
                if (held_v) chk("stall_stable", s_axi_rdata, held);
                if (s_axi_rready) begin
                    chk("beat_data", s_axi_rdata, exp_data[k]);
                    chk("beat_rid", {51'd0, s_axi_rid}, {51'd0, id});
                    chk("beat_rlast", {63'd0, s_axi_rlast}, {63'd0, (k == n - 1)});
                    chk("beat_rresp", {62'd0, s_axi_rresp}, {62'd0, exp_resp[k]});
                    k++;
                    held_v = 1'b0;
                end else begin
                    held = s_axi_rdata;
                    held_v = 1'b1;
                end
            end
        end
        chk("beat_count", 64'(k), 64'(stop));
    endtask

    task automatic end_check();
        @(negedge clk);
        chk("post_rvalid", {63'd0, s_axi_rvalid}, 64'd0);
        chk("post_arready", {63'd0, s_axi_arready}, 64'd1);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) begin
            exp_data[i] = '0;
            exp_resp[i] = 2'b00;
        end
    endtask

    initial begin
        reset = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'b011;
        s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_arready", {63'd0, s_axi_arready}, 64'd0);
        chk("rst_rvalid", {63'd0, s_axi_rvalid}, 64'd0);
        chk("rst_rlast", {63'd0, s_axi_rlast}, 64'd0);
        chk("rst_rid", {51'd0, s_axi_rid}, 64'd0);
        chk("rst_rdata", s_axi_rdata, 64'd0);
        chk("rst_rresp", {62'd0, s_axi_rresp}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            mem_we = 1'b1; mem_waddr = 10'(i); mem_wdata = 64'h1000 + 64'(i);
            @(negedge clk);
        end
        mem_waddr = 10'd1023; mem_wdata = 64'hABCD_0000_0000_03FF;
        @(negedge clk);
        mem_we = 1'b0;
        reset = 1'b0;

        // INCR len 7 from 0, first beat three cycles after the handshake cycle
        clear_exp();
        for (int i = 0; i < 8; i++) exp_data[i] = 64'h1000 + 64'(i);
        send_ar(13'd5, 64'h0, 8'd7, 2'b01);
        @(negedge clk);
        chk("lat_cycle1", {63'd0, s_axi_rvalid}, 64'd0);
        @(negedge clk);
        chk("lat_cycle2", {63'd0, s_axi_rvalid}, 64'd0);
        collect(8, 8, 1'b0, 1'b1, 13'd5);
        end_check();

        // WRAP len 7 from 0x28
        clear_exp();
        exp_data[0] = 64'h1005; exp_data[1] = 64'h1006; exp_data[2] = 64'h1007;
        exp_data[3] = 64'h1000; exp_data[4] = 64'h1001; exp_data[5] = 64'h1002;
        exp_data[6] = 64'h1003; exp_data[7] = 64'h1004;
        send_ar(13'd7, 64'h28, 8'd7, 2'b10);
        collect(8, 8, 1'b0, 1'b0, 13'd7);
        end_check();

        // INCR len 7 with rready toggling
        clear_exp();
        for (int i = 0; i < 8; i++) exp_data[i] = 64'h1000 + 64'(i);
        send_ar(13'd5, 64'h0, 8'd7, 2'b01);
        collect(8, 8, 1'b1, 1'b0, 13'd5);
        end_check();

        // FIXED len 3 at 0x18
        clear_exp();
        for (int i = 0; i < 4; i++) exp_data[i] = 64'h1003;
        send_ar(13'd2, 64'h18, 8'd3, 2'b00);
        collect(4, 4, 1'b0, 1'b0, 13'd2);
        end_check();

        // Reset after two beats of an eight-beat burst, then a fresh request
        clear_exp();
        for (int i = 0; i < 8; i++) exp_data[i] = 64'h1000 + 64'(i);
        send_ar(13'd3, 64'h0, 8'd7, 2'b01);
        collect(8, 2, 1'b0, 1'b0, 13'd3);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rvalid", {63'd0, s_axi_rvalid}, 64'd0);
        reset = 1'b0;
        clear_exp();
        exp_data[0] = 64'h1008;
        send_ar(13'd9, 64'h40, 8'd0, 2'b01);
        collect(1, 1, 1'b0, 1'b0, 13'd9);
        end_check();

        // INCR len 1 crossing the top of memory
        clear_exp();
        exp_data[0] = 64'hABCD_0000_0000_03FF;
`ifdef AXI_RD_ERR_CHECK_EN
        exp_data[1] = 64'h0;
        exp_resp[1] = 2'b10;
`else
        exp_data[1] = 64'h1000;
`endif
        send_ar(13'd4, 64'h1FF8, 8'd1, 2'b01);
        collect(2, 2, 1'b0, 1'b0, 13'd4);
        end_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
